// File: rtl/cr_ob_rx_pkg.sv
// cr_ob_rx_pkg
// Shared definitions for the outbound-stream frame receiver:
//   - tuser framing encodings carried on ob_tuser
//   - receiver state encoding
//   - bit positions inside stat_err
package cr_ob_rx_pkg;

  // Framing codes carried in ob_tuser
  localparam logic [7:0] TUSER_MID     = 8'h00;
  localparam logic [7:0] TUSER_SOT     = 8'h01;
  localparam logic [7:0] TUSER_EOT     = 8'h02;
  localparam logic [7:0] TUSER_SOT_EOT = 8'h03;

  // Receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    REPORT = 2'd2
  } rx_state_e;

  // stat_err bit positions
  localparam int ERR_SAT = 0;  // byte or beat counter saturated
  localparam int ERR_SOT = 1;  // frame ended by SoT / SoT-EoT beat

endpackage

// File: rtl/cr_ob_rx_popcnt.sv
// cr_ob_rx_popcnt
// Combinational population count of a byte-strobe vector.
// Ports:
//   strb  in   STRB_W  byte strobes (any pattern, non-contiguous allowed)
//   cnt   out  CNT_W   number of set bits
module cr_ob_rx_popcnt #(
  parameter int STRB_W = 8,
  parameter int CNT_W  = $clog2(STRB_W) + 1
) (
  input  logic [STRB_W-1:0] strb,
  output logic [CNT_W-1:0]  cnt
);

  // Sum every strobe bit
  always_comb begin
    cnt = '0;
    for (int i = 0; i < STRB_W; i++) begin
      cnt = cnt + CNT_W'(strb[i]);
    end
  end

endmodule

// File: rtl/cr_ob_frame_rx.sv
// cr_ob_frame_rx
// Receiver for the engine's outbound AXI-Stream. Header frames are skipped
// until the data-frame SoT beat (tuser SoT with tdata[7:0] == DATA_TAG);
// payload bytes (tstrb popcount) and beats are then counted up to the frame
// terminator and the totals are offered on a valid/ready status port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sink_en             1 permits acceptance of ob beats
//   ob_t*               outbound stream (ob_tlast is not used for framing)
//   stat_valid/ready    frame result handshake
//   stat_len/beats      payload bytes / beats of the reported frame
//   stat_tid            tid captured on the data SoT beat
//   stat_err            [0] counter saturated, [1] SoT seen inside frame
//   frame_cnt           frames reported since reset, wraps
module cr_ob_frame_rx
  import cr_ob_rx_pkg::*;
#(
  parameter int         DATA_W   = 64,
  parameter int         STRB_W   = 8,
  parameter int         USER_W   = 8,
  parameter int         TID_W    = 1,
  parameter int         LEN_W    = 32,
  parameter logic [7:0] DATA_TAG = 8'h05
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sink_en,
  input  logic              ob_tvalid,
  output logic              ob_tready,
  input  logic [DATA_W-1:0] ob_tdata,
  input  logic [STRB_W-1:0] ob_tstrb,
  input  logic [USER_W-1:0] ob_tuser,
  input  logic [TID_W-1:0]  ob_tid,
  input  logic              ob_tlast,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [LEN_W-1:0]  stat_len,
  output logic [LEN_W-1:0]  stat_beats,
  output logic [TID_W-1:0]  stat_tid,
  output logic [1:0]        stat_err,
  output logic [LEN_W-1:0]  frame_cnt
);

  localparam int CNT_W = $clog2(STRB_W) + 1;

  rx_state_e          state_q, state_d;
  logic               ob_tready_q, ob_tready_d;
  logic               stat_valid_q, stat_valid_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic [1:0]         err_q, err_d;
  logic [LEN_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               accept_s;
  logic               count_s;
  logic               data_sot_s;
  logic [CNT_W-1:0]   pop_s;
  logic [LEN_W:0]     len_sum_s;
  logic [LEN_W:0]     beats_sum_s;
  logic [LEN_W-1:0]   len_next_s;
  logic [LEN_W-1:0]   beats_next_s;
  logic               sat_s;
  logic               unused_s;

  assign unused_s = ^{ob_tdata[DATA_W-1:8], ob_tlast};

  cr_ob_rx_popcnt #(
    .STRB_W (STRB_W),
    .CNT_W  (CNT_W)
  ) u_popcnt (
    .strb (ob_tstrb),
    .cnt  (pop_s)
  );

  assign accept_s   = ob_tvalid & ob_tready_q;
  assign data_sot_s = (ob_tuser == USER_W'(TUSER_SOT)) & (ob_tdata[7:0] == DATA_TAG);

  // Saturating running totals; the extra MSB of each sum flags overflow
  always_comb begin
    len_sum_s    = {1'b0, len_q} + (LEN_W+1)'(pop_s);
    beats_sum_s  = {1'b0, beats_q} + (LEN_W+1)'(1'b1);
    len_next_s   = len_sum_s[LEN_W]   ? {LEN_W{1'b1}} : len_sum_s[LEN_W-1:0];
    beats_next_s = beats_sum_s[LEN_W] ? {LEN_W{1'b1}} : beats_sum_s[LEN_W-1:0];
    sat_s        = len_sum_s[LEN_W] | beats_sum_s[LEN_W];
  end

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    tid_d       = tid_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    count_s     = 1'b0;

    case (state_q)
      IDLE: begin
        // Only the tagged SoT opens a frame; everything else is dropped
        if (accept_s && data_sot_s) begin
          state_d = DATA;
          len_d   = '0;
          beats_d = '0;
          tid_d   = ob_tid;
          err_d   = 2'b00;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (accept_s) begin
          case (ob_tuser)
            USER_W'(TUSER_SOT): begin
              // A new SoT closes the frame uncounted with the totals so far
              err_d[ERR_SOT] = 1'b1;
              state_d        = REPORT;
            end
            USER_W'(TUSER_EOT): begin
              count_s = 1'b1;
              state_d = REPORT;
            end
            USER_W'(TUSER_SOT_EOT): begin
              count_s        = 1'b1;
              err_d[ERR_SOT] = 1'b1;
              state_d        = REPORT;
            end
            default: begin
              // TUSER_MID and any unknown code are plain payload beats
              count_s = 1'b1;
            end
          endcase
        end else begin
          state_d = DATA;
        end
      end
      REPORT: begin
        if (stat_valid_q && stat_ready) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + LEN_W'(1'b1);
        end else begin
          state_d = REPORT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    len_d          = count_s ? len_next_s : len_d;
    beats_d        = count_s ? beats_next_s : beats_d;
    err_d[ERR_SAT] = err_d[ERR_SAT] | (count_s & sat_s);

    // Looking at state_d lets ready drop together with the terminating
    // beat and rise in the same cycle stat_valid falls
    ob_tready_d  = sink_en & (state_d != REPORT);
    stat_valid_d = (state_d == REPORT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ob_tready_q  <= 1'b0;
      stat_valid_q <= 1'b0;
      len_q        <= '0;
      beats_q      <= '0;
      tid_q        <= '0;
      err_q        <= 2'b00;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ob_tready_q  <= ob_tready_d;
      stat_valid_q <= stat_valid_d;
      len_q        <= len_d;
      beats_q      <= beats_d;
      tid_q        <= tid_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign ob_tready  = ob_tready_q;
  assign stat_valid = stat_valid_q;
  assign stat_len   = len_q;
  assign stat_beats = beats_q;
  assign stat_tid   = tid_q;
  assign stat_err   = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cr_ob_frame_rx.sv
module tb_cr_ob_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sink_en;
  logic        ob_tvalid;
  logic [63:0] ob_tdata;
  logic [7:0]  ob_tstrb;
  logic [7:0]  ob_tuser;
  logic        ob_tid;
  logic        ob_tlast;
  logic        stat_ready;

  logic        ob_tready,  ob_tready4;
  logic        stat_valid, stat_valid4;
  logic [31:0] stat_len, stat_beats, frame_cnt;
  logic [3:0]  stat_len4, stat_beats4, frame_cnt4;
  logic        stat_tid, stat_tid4;
  logic [1:0]  stat_err, stat_err4;

  always #5 clk = ~clk;

  cr_ob_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready), .ob_tdata(ob_tdata),
    .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_len(stat_len),
    .stat_beats(stat_beats), .stat_tid(stat_tid), .stat_err(stat_err),
    .frame_cnt(frame_cnt)
  );

  cr_ob_frame_rx #(.LEN_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sink_en(sink_en),
    .ob_tvalid(ob_tvalid), .ob_tready(ob_tready4), .ob_tdata(ob_tdata),
    .ob_tstrb(ob_tstrb), .ob_tuser(ob_tuser), .ob_tid(ob_tid), .ob_tlast(ob_tlast),
    .stat_valid(stat_valid4), .stat_ready(stat_ready), .stat_len(stat_len4),
    .stat_beats(stat_beats4), .stat_tid(stat_tid4), .stat_err(stat_err4),
    .frame_cnt(frame_cnt4)
  );

  typedef struct {
    logic [7:0]  tuser;
    logic [63:0] tdata;
    logic [7:0]  strb;
    logic        tid;
    logic        tlast;
    bit          term;
  } beat_t;

  typedef struct {
    logic [31:0] len;
    logic [31:0] beats;
    logic        tid;
    logic [1:0]  err;
  } exp_t;

  beat_t beat_q[$];
  exp_t  sb32[$];
  exp_t  sb4[$];

  int n_chk  = 0;
  int n_fail = 0;
  int sink_mode = 0;   // 0 always on, 1 toggle, 2 random
  int rdy_mode  = 0;   // 0 always ready, 1 hold off 10 cycles, 2 random
  int term_acc  = 0;   // terminating beats accepted (driver)
  int exp_fc    = 0;   // frames expected to be reported (monitor)

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic beat_t mk(input logic [7:0] tu, input logic [63:0] d,
                               input logic [7:0] s, input bit term);
    beat_t b;
    b.tuser = tu; b.tdata = d; b.strb = s; b.term = term;
    b.tid = 1'($urandom); b.tlast = 1'($urandom);
    return b;
  endfunction

  // Reference: clip totals at the counter maximum, flag any overflow
  function automatic exp_t mkexp(input longint total, input longint nb, input logic tid,
                                 input logic sot_err, input longint maxv);
    exp_t e;
    e.len    = 32'(total > maxv ? maxv : total);
    e.beats  = 32'(nb > maxv ? maxv : nb);
    e.tid    = tid;
    e.err[0] = (total > maxv) || (nb > maxv);
    e.err[1] = sot_err;
    return e;
  endfunction

  // Beat that must be ignored outside a frame
  task automatic add_junk();
    logic [63:0] d;
    logic [7:0]  tu;
    d = rand64();
    case ($urandom_range(0, 4))
      0: begin tu = 8'h01; if (d[7:0] == 8'h05) d[7:0] = 8'h06; end
      1: tu = 8'h02;
      2: tu = 8'h03;
      3: tu = 8'h00;
      default: begin tu = 8'($urandom); if (tu == 8'h01) tu = 8'h40; end
    endcase
    beat_q.push_back(mk(tu, d, 8'($urandom), 1'b0));
  endtask

  function automatic logic [7:0] pick_strb();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hff;
      default: return 8'($urandom);
    endcase
  endfunction

  // Data SoT, n_body payload beats, terminator; optionally scoreboarded
  task automatic add_frame(input int n_body, input logic [7:0] body_strb, input bit rand_strb,
                           input logic [7:0] term_tu, input logic [7:0] term_strb,
                           input bit with_term);
    beat_t  b;
    logic [63:0] d;
    logic [7:0]  s, tu;
    longint total, nb;
    total = 0; nb = n_body;
    d = rand64(); d[7:0] = 8'h05;
    b = mk(8'h01, d, 8'($urandom), 1'b0);
    beat_q.push_back(b);
    for (int i = 0; i < n_body; i++) begin
      s  = rand_strb ? pick_strb() : body_strb;
      tu = ($urandom_range(0, 2) != 0) ? 8'h00 : 8'($urandom_range(4, 255));
      total += $countones(s);
      beat_q.push_back(mk(tu, rand64(), s, 1'b0));
    end
    if (with_term) begin
      beat_q.push_back(mk(term_tu, rand64(), term_strb, 1'b1));
      if (term_tu != 8'h01) begin
        total += $countones(term_strb);
        nb++;
      end
      sb32.push_back(mkexp(total, nb, b.tid, term_tu != 8'h02, longint'(32'hFFFF_FFFF)));
      sb4.push_back(mkexp(total, nb, b.tid, term_tu != 8'h02, 15));
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int cyc;
    cyc = 0;
    while ((beat_q.size() != 0 || ob_tvalid || sb32.size() != 0 || stat_valid) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: drain timeout, beats left=%0d reports left=%0d", nm, beat_q.size(), sb32.size());
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_tready"}, {ob_tready, ob_tready4}, 0);
    chk({nm, "_valid"}, {stat_valid, stat_valid4}, 0);
    chk({nm, "_len"}, {stat_len, stat_len4}, 0);
    chk({nm, "_beats"}, {stat_beats, stat_beats4}, 0);
    chk({nm, "_tid_err"}, {stat_tid, stat_tid4, stat_err, stat_err4}, 0);
    chk({nm, "_fcnt"}, {frame_cnt, frame_cnt4}, 0);
  endtask

  // Stream driver: holds each beat until accepted
  initial begin : driver
    beat_t cur;
    bit    have, acc;
    have = 1'b0;
    ob_tvalid = 1'b0; ob_tdata = '0; ob_tstrb = '0; ob_tuser = '0;
    ob_tid = 1'b0; ob_tlast = 1'b0; sink_en = 1'b0;
    forever begin
      @(negedge clk);
      acc = ob_tvalid && ob_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (cur.term) term_acc++;
        have = 1'b0;
      end
      if (!have && beat_q.size() != 0) begin
        cur  = beat_q.pop_front();
        have = 1'b1;
      end
      ob_tvalid = have;
      if (have) begin
        ob_tdata = cur.tdata; ob_tstrb = cur.strb; ob_tuser = cur.tuser;
        ob_tid = cur.tid; ob_tlast = cur.tlast;
      end else begin
        ob_tdata = rand64(); ob_tstrb = 8'($urandom); ob_tuser = 8'h01;
        ob_tid = 1'($urandom); ob_tlast = 1'($urandom);
      end
      case (sink_mode)
        0: sink_en = 1'b1;
        1: sink_en = ~sink_en;
        default: sink_en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard: compares every cycle a report is presented
  initial begin : monitor
    exp_t e, e4;
    bit   hs, prev_hs;
    logic prev_sink;
    int   hold, term_seen;
    stat_ready = 1'b0; prev_hs = 1'b0; prev_sink = 1'b0; hold = 0; term_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_fc = 0; prev_hs = 1'b0; hold = 0; stat_ready = 1'b0; term_seen = term_acc;
      end else begin
        hs = 1'b0;
        chk("frame_cnt", frame_cnt, 64'(exp_fc));
        chk("frame_cnt_w4", frame_cnt4, 64'(exp_fc % 16));
        if (term_acc != term_seen) begin
          chk("report_latency", stat_valid, 1);
          term_seen = term_acc;
        end
        if (prev_hs) begin
          chk("tready_after_ack", ob_tready, prev_sink);
          chk("tready_after_ack_w4", ob_tready4, prev_sink);
        end
        if (stat_valid) begin
          chk("tready_in_report", {ob_tready, ob_tready4}, 0);
          chk("valid_w4", stat_valid4, 1);
          if (sb32.size() == 0 || sb4.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_report: len=%0d beats=%0d with empty scoreboard", stat_len, stat_beats);
          end else begin
            e = sb32[0]; e4 = sb4[0];
            chk("stat_len", stat_len, e.len);
            chk("stat_beats", stat_beats, e.beats);
            chk("stat_tid", stat_tid, e.tid);
            chk("stat_err", stat_err, e.err);
            chk("stat_len_w4", stat_len4, e4.len);
            chk("stat_beats_w4", stat_beats4, e4.beats);
            chk("stat_tid_w4", stat_tid4, e4.tid);
            chk("stat_err_w4", stat_err4, e4.err);
            case (rdy_mode)
              0: stat_ready = 1'b1;
              1: stat_ready = (hold >= 10);
              default: stat_ready = 1'($urandom);
            endcase
            hold++;
            if (stat_ready) begin
              hs = 1'b1; hold = 0; exp_fc++;
              void'(sb32.pop_front());
              void'(sb4.pop_front());
            end
          end
        end else begin
          chk("valid_w4_idle", stat_valid4, 0);
          stat_ready = 1'($urandom);
        end
        prev_hs = hs; prev_sink = sink_en;
      end
    end
  end

  initial begin : main
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(posedge clk); #2 rst_n = 1'b1;

    // Partial frame killed by reset, then a one-beat frame
    add_frame(2, 8'hff, 1'b0, 8'h02, 8'h00, 1'b0);
    wait_drain("partial", 200);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk); #2 rst_n = 1'b1;
    add_frame(0, 8'h00, 1'b0, 8'h02, 8'h01, 1'b1);
    wait_drain("after_reset", 200);
    chk("fcnt_after_reset", frame_cnt, 1);

    // Header frame skipped, then 3 full beats plus EoT with 3 bytes
    beat_q.push_back(mk(8'h01, 64'h0000_0000_0a00_0400, 8'hff, 1'b0));
    add_frame(3, 8'hff, 1'b0, 8'h02, 8'h07, 1'b1);
    wait_drain("basic", 200);

    // Same frame with stat_ready held off
    rdy_mode = 1;
    beat_q.push_back(mk(8'h01, 64'h0000_0000_0a00_0400, 8'hff, 1'b0));
    add_frame(3, 8'hff, 1'b0, 8'h02, 8'h07, 1'b1);
    wait_drain("stall", 300);
    rdy_mode = 0;

    // Frame cut short by a new SoT
    add_frame(2, 8'hff, 1'b0, 8'h01, 8'hff, 1'b1);
    wait_drain("sot_in_frame", 200);

    // sink_en toggling every cycle across a 5-beat frame
    sink_mode = 1;
    add_frame(4, 8'hff, 1'b0, 8'h02, 8'hff, 1'b1);
    wait_drain("sink_toggle", 300);
    sink_mode = 0;

    // Randomized traffic with random back-pressure on both sides
    sink_mode = 2; rdy_mode = 2;
    for (int blk = 0; blk < 5; blk++) begin
      for (int f = 0; f < 30; f++) begin
        int nj;
        logic [7:0] tt;
        nj = $urandom_range(0, 2);
        for (int j = 0; j < nj; j++) add_junk();
        case ($urandom_range(0, 3))
          0: tt = 8'h01;
          1: tt = 8'h03;
          default: tt = 8'h02;
        endcase
        add_frame($urandom_range(0, 20), 8'h00, 1'b1, tt, pick_strb(), 1'b1);
      end
      wait_drain("random", 20000);
    end

    chk("sb_empty", {32'(sb32.size()), 32'(sb4.size())}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
